// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Used by mem_port_arbiter and by its optional starvation counter
// (compiled in with ARB_FAIRNESS_EN).
package mem_arb_pkg;

    // Who currently owns the memory port.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_D  = 2'b10
    } arb_state_e;

    // Which requester won the arbitration.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    localparam int MASK_W   = 3;
    localparam logic [MASK_W-1:0] MASK_WORD = 3'b010;
    localparam int LAT_W    = 3;
    localparam int STARVE_W = 4;

    // In-flight state that follows a grant to the given owner.
    function automatic arb_state_e busy_state(input arb_owner_e owner);
        return (owner == OWN_D) ? BUSY_D : BUSY_IF;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Starvation counter for the fetch requester. Counts data grants made while
// a fetch is waiting and raises force_fetch_o once STARVE_MAX of them have
// gone by. Only instantiated when ARB_FAIRNESS_EN is defined.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req_i,
    input  logic if_gnt_i,
    input  logic d_gnt_i,
    output logic force_fetch_o
);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    // Next count: a waiting fetch accumulates data grants, anything else clears.
    always_comb begin
        cnt_d = cnt_q;
        if (!if_req_i || if_gnt_i) begin
            cnt_d = '0;
        end else if (d_gnt_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count can never pass STARVE_MAX: at that value the next grant
    // goes to the fetch, which clears the counter.
    assign force_fetch_o = (cnt_q == STARVE_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-port unified memory shared by the fetch
// path and the load/store path. Grants one requester per free cycle, drives
// the memory command, times the access with a latency counter and routes
// read data plus a valid strobe back to the owner.
// Optional fetch-fairness override: define ARB_FAIRNESS_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    // fetch requester
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    // load/store requester
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [MASK_W-1:0] d_mask_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    // memory macro
    output logic              mem_cs_o,
    output logic              mem_we_o,
    output logic [MASK_W-1:0] mem_mask_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    // status
    output logic              busy_o
);

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..7");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [LAT_W-1:0] lat_cnt_q;
    logic [LAT_W-1:0] lat_cnt_d;

    logic       free;
    logic       resp;
    logic       force_fetch;
    logic       grant;
    arb_owner_e win_owner;

    // Free when nothing is in flight, or in the response cycle of the current
    // access so a new command can go out back-to-back with the old response.
    assign free = (state_q == IDLE) || (lat_cnt_q == LAT_W'(1));
    assign resp = (state_q != IDLE) && (lat_cnt_q == LAT_W'(1));

`ifdef ARB_FAIRNESS_EN
    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk           (clk),
        .reset         (reset),
        .if_req_i      (if_req_i),
        .if_gnt_i      (if_gnt_o),
        .d_gnt_i       (d_gnt_o),
        .force_fetch_o (force_fetch)
    );
`else
    // Strict data priority: a steady data stream may starve the fetch.
    assign force_fetch = 1'b0;
`endif

    // Pick at most one winner per free cycle; data wins unless a starved
    // fetch is being forced through. No grant while reset is held low.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the block can leave it unassigned and infer a latch.
        grant     = 1'b0;
        win_owner = OWN_D;
        if (reset && free) begin
            if (if_req_i && (!d_req_i || force_fetch)) begin
                grant     = 1'b1;
                win_owner = OWN_IF;
            end else if (d_req_i) begin
                grant     = 1'b1;
                win_owner = OWN_D;
            end
        end
    end

    assign if_gnt_o = grant && (win_owner == OWN_IF);
    assign d_gnt_o  = grant && (win_owner == OWN_D);

    // Memory command mux: driven from the winner in the grant cycle, else 0.
    always_comb begin
        mem_cs_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_mask_o  = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (if_gnt_o) begin
            mem_cs_o   = 1'b1;
            mem_mask_o = MASK_WORD;
            mem_addr_o = if_addr_i;
        end else if (d_gnt_o) begin
            mem_cs_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_mask_o  = d_mask_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end
    end

    // Next state: a grant reloads for the new owner (even in a response
    // cycle); otherwise count down and drop to IDLE after the response.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        if (grant) begin
            state_d   = busy_state(win_owner);
            lat_cnt_d = LAT_W'(MEM_LAT);
        end else if (state_q != IDLE) begin
            lat_cnt_d = lat_cnt_q - 1'b1;
            if (lat_cnt_q == LAT_W'(1)) begin
                state_d = IDLE;
            end
        end
    end

    // State and latency registers; reset discards any in-flight access.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of block order.
        if (!reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Response routing: the owner of the expiring access gets the strobe.
    assign if_rvalid_o = resp && (state_q == BUSY_IF);
    assign d_rvalid_o  = resp && (state_q == BUSY_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
    assign d_rdata_o   = d_rvalid_o  ? mem_rdata_i : 32'h0;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MEM_LAT=3, STARVE_MAX=4).
// Expectations follow ARB_FAIRNESS_EN the same way the design does.
module tb_mem_port_arbiter;

    localparam int unsigned LAT  = 3;
    localparam int unsigned SMAX = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
    logic [2:0]  d_mask_i;
    logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic        mem_cs_o, mem_we_o, busy_o;
    logic [2:0]  mem_mask_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_mask_i(d_mask_i),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_mask_o(mem_mask_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Expected observable outputs for one cycle.
    typedef struct {
        int          cyc;
        logic        if_gnt, d_gnt, cs, we, busy, if_rv, d_rv;
        logic [2:0]  mask;
        logic [31:0] addr, wdata, if_rd, d_rd;
    } exp_t;

    // An issued access awaiting its response.
    typedef struct {
        bit is_d;
        int due;
    } resp_t;

    exp_t  exp_q[$];
    resp_t inflight_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int starve_m = 0;
    bit last_gi  = 0;
    bit last_gd  = 0;

    // Request state used by the stimulus loops.
    logic        r_ifr = 0, r_dr = 0, r_dwe = 0;
    logic [31:0] r_ifa = 0, r_da = 0, r_dwd = 0;
    logic [2:0]  r_dm = 0;

    task automatic check(input string name, input int c,
                         input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %h want %h", name, c, act, req);
        end
    endtask

    // Drive one cycle of inputs and predict the DUT response from the rules:
    // port free if nothing in flight or the in-flight access answers now;
    // data beats fetch unless the fetch has waited SMAX data grants.
    task automatic step(input logic rst, input logic ifr, input logic [31:0] ifa,
                        input logic dr, input logic dwe, input logic [2:0] dm,
                        input logic [31:0] da, input logic [31:0] dwd);
        exp_t  e;
        resp_t r;
        bit    rsp, free, gi, gd;
        @(posedge clk);
        #1;
        reset = rst; if_req_i = ifr; if_addr_i = ifa;
        d_req_i = dr; d_we_i = dwe; d_mask_i = dm; d_addr_i = da; d_wdata_i = dwd;
        mem_rdata_i = $urandom;
        cyc++;
        e.cyc = cyc;
        e.busy = (inflight_q.size() != 0);
        e.if_rv = 0; e.d_rv = 0; e.if_rd = 0; e.d_rd = 0;
        rsp = 0;
        if (inflight_q.size() != 0 && inflight_q[0].due == cyc) begin
            r = inflight_q.pop_front();
            rsp = 1;
            if (r.is_d) begin e.d_rv = 1; e.d_rd = mem_rdata_i; end
            else        begin e.if_rv = 1; e.if_rd = mem_rdata_i; end
        end
        free = !e.busy || rsp;
        gi = 0; gd = 0;
        if (rst && free) begin
            if (ifr && (!dr || (FAIR && starve_m == SMAX))) gi = 1;
            else if (dr) gd = 1;
        end
        if (!rst || !ifr || gi) starve_m = 0;
        else if (gd) starve_m++;
        e.if_gnt = gi; e.d_gnt = gd; e.cs = gi | gd;
        e.we = 0; e.mask = 0; e.addr = 0; e.wdata = 0;
        if (gi) begin
            e.mask = 3'b010; e.addr = ifa;
            inflight_q.push_back('{is_d: 1'b0, due: cyc + LAT});
        end else if (gd) begin
            e.we = dwe; e.mask = dm; e.addr = da; e.wdata = dwd;
            inflight_q.push_back('{is_d: 1'b1, due: cyc + LAT});
        end
        if (!rst) inflight_q.delete();
        exp_q.push_back(e);
        last_gi = gi;
        last_gd = gd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the DUT against the oldest expectation mid-cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cmd", e.cyc,
                      {56'h0, if_gnt_o, d_gnt_o, mem_cs_o, mem_we_o, mem_mask_o,
                       mem_addr_o, mem_wdata_o, busy_o},
                      {56'h0, e.if_gnt, e.d_gnt, e.cs, e.we, e.mask,
                       e.addr, e.wdata, e.busy});
                check("rsp", e.cyc,
                      {62'h0, if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o},
                      {62'h0, e.if_rv, e.d_rv, e.if_rd, e.d_rd});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        int guard;
        reset = 0; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0;
        d_mask_i = 0; d_addr_i = 0; d_wdata_i = 0; mem_rdata_i = 0;

        // Reset held: all outputs quiet.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h40, 1, 0, 3'b010, 32'h80, 0);

        // Lone fetch.
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        idle(LAT + 1);

        // Collision: load wins, fetch follows in the load's response cycle.
        step(1, 1, 32'h400, 1, 0, 3'b010, 32'h2000, 32'h5555);
        guard = 0;
        while (!last_gi && guard < 8) begin
            step(1, 1, 32'h400, 0, 0, 0, 0, 0);
            guard++;
        end
        idle(LAT + 1);

        // Byte store.
        step(1, 0, 0, 1, 1, 3'b000, 32'h3, 32'hAB);
        idle(LAT + 1);

        // Continuous data with a fetch waiting: back-to-back grants; the
        // fetch only gets in through the fairness override.
        r_da = 32'h1000; r_dwe = 0; r_dm = 3'b010; r_dwd = $urandom;
        r_ifa = 32'h500;
        for (int i = 0; i < 45; i++) begin
            step(1, 1, r_ifa, 1, r_dwe, r_dm, r_da, r_dwd);
            if (last_gd) begin
                r_da = r_da + 4; r_dwe = $urandom_range(0, 1); r_dwd = $urandom;
            end
            if (last_gi) r_ifa = r_ifa + 4;
        end
        idle(LAT + 1);

        // Reset two cycles after a fetch grant: response must vanish.
        step(1, 1, 32'h700, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(LAT + 2);

        // Randomized traffic with legal hold/drop behaviour.
        r_ifr = 0; r_dr = 0;
        for (int i = 0; i < 600; i++) begin
            if (!r_ifr || last_gi) begin
                r_ifr = ($urandom_range(0, 2) != 0);
                r_ifa = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 15) == 0) begin
                r_ifr = 0;
            end
            if (!r_dr || last_gd) begin
                r_dr  = ($urandom_range(0, 2) == 0);
                r_dwe = $urandom_range(0, 1);
                r_dm  = $urandom_range(0, 7);
                r_da  = $urandom;
                r_dwd = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                r_dr = 0;
            end
            step(1, r_ifr, r_ifa, r_dr, r_dwe, r_dm, r_da, r_dwd);
        end

        // Drain so every outstanding response is compared.
        idle(LAT + 2);
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for a single-port unified memory shared by the instruction-fetch path and the load/store path of the 3-stage core. It grants one requester per free cycle, drives the memory command and tracks the in-flight access with a latency counter. It then routes the read data and a valid strobe back to the owning requester. It sits between the PC/C-extension fetch logic, the data-memory stage and the memory macro.

## Interface
- MEM_LAT, 1: cycles from command issue to `mem_rdata_i` valid; legal range 1–7.
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending; legal range 1–15. Used only with fairness compiled in.

- clk  in  1  core clock. Single clock domain.
- reset  in  1  synchronous, active-low reset.
- if_req_i  in  1  fetch request. Held with stable `if_addr_i` until `if_gnt_o`.
- if_addr_i  in  32  fetch address.
- if_gnt_o  out  1  fetch command accepted this cycle.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  32  fetch read data.
- d_req_i  in  1  data request. Held with stable attributes until `d_gnt_o`.
- d_we_i  in  1  1 = store, 0 = load.
- d_mask_i  in  3  byte/half/word mask code, same encoding as the data-memory mask.
- d_addr_i  in  32  data address.
- d_wdata_i  in  32  store data.
- d_gnt_o  out  1  data command accepted this cycle.
- d_rvalid_o  out  1  load data valid, or store completion.
- d_rdata_o  out  32  load data.
- mem_cs_o  out  1  memory chip select. Equals `if_gnt_o | d_gnt_o`.
- mem_we_o  out  1  memory write enable.
- mem_mask_o  out  3  memory mask.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data.
- busy_o  out  1  an access is in flight.

## Operation
- States:
  - IDLE: nothing in flight.
  - BUSY_IF: a fetch access is in flight.
  - BUSY_D: a data access is in flight.
- Latency counter `lat_cnt` (3 bits):
  - Loaded with MEM_LAT on a grant.
  - Decrements each cycle while not IDLE.
- Arbiter is free when state is IDLE, or when `lat_cnt == 1`. The second case is the response cycle and allows back-to-back grants.
- Grant rule when free:
  - `d_req_i` wins over `if_req_i`.
  - Fetch is granted only if no data request is present, except under fairness override (see Configuration).
  - At most one grant per cycle.
  - No grant when not free.
- Grant cycle:
  - `mem_*` outputs are driven combinationally from the winner.
  - For a fetch grant: `mem_we_o = 0` and `mem_mask_o = 3'b010` (word).
  - When no grant, `mem_*` outputs are 0.
- Transitions:
  - Fetch grant → BUSY_IF.
  - Data grant → BUSY_D.
  - `lat_cnt == 1` with no new grant → IDLE.
- Response cycle (`lat_cnt == 1`):
  - The owner's `*_rvalid_o` pulses for 1 cycle.
  - `*_rdata_o` equals `mem_rdata_i`. `*_rdata_o` is 0 when the matching rvalid is low.
  - For stores, `d_rvalid_o` still pulses as the completion acknowledge.
- `busy_o` is 1 whenever state ≠ IDLE.
- A request dropped before its grant is legal: nothing is issued and no response is produced.

## Timing
- `*_gnt_o` is combinational in the request cycle when the arbiter is free, so it has 0-cycle grant latency.
- Response arrives exactly MEM_LAT cycles after the grant edge.
- With MEM_LAT = 1, sustained throughput is one access per cycle.
- Simultaneous requests: data is granted first. Fetch is granted in the data response cycle if data does not request again.
- Response and new grant in the same cycle: rvalid goes to the old owner, and the state and `lat_cnt` reload for the new owner.
- Reset (`reset == 0` at a clock edge):
  - State → IDLE, `lat_cnt` → 0, starvation counter → 0.
  - All outputs are 0 in the following cycle.
  - An in-flight response is discarded; no rvalid is emitted after reset.
  - Grants are suppressed while `reset` is low.

## Configuration
- `ARB_FAIRNESS_EN` defined:
  - A starvation counter (4 bits) increments on each data grant made while `if_req_i` is high.
  - The counter clears on a fetch grant, or on any cycle with `if_req_i` low.
  - When counter == STARVE_MAX and the arbiter is free, fetch wins over data for that grant.
- `ARB_FAIRNESS_EN` not defined:
  - Strict data priority; the counter logic is absent.
  - A continuous data stream may starve fetch indefinitely.

## Structure
- `mem_arb_pkg` holds:
  - `arb_state_e` (IDLE, BUSY_IF, BUSY_D).
  - `arb_owner_e` (OWN_IF, OWN_D).
  - `MASK_W = 3` and `MASK_WORD = 3'b010`.
  - `LAT_W = 3`.
- One sub-module, `arb_starve_ctr`: the starvation counter and force-fetch flag. It is instantiated only under `ARB_FAIRNESS_EN`.
- Everything else is flat: one state register, `lat_cnt`, and combinational grant/mux logic.

## Test plan
- Lone fetch: MEM_LAT=2, `if_req_i` held with address 0x100.
  - `if_gnt_o` and `mem_cs_o` are 1 in cycle 0, with `mem_addr_o` = 0x100 and `mem_we_o` = 0.
  - `if_rvalid_o` is 1 in cycle 2 with `if_rdata_o` = `mem_rdata_i`.
- Collision: MEM_LAT=1, fetch and load (address 0x2000) requested in the same cycle.
  - `d_gnt_o` in cycle 0 and `if_gnt_o` in cycle 1.
  - `d_rvalid_o` in cycle 1 and `if_rvalid_o` in cycle 2.
- Store: `d_we_i=1`, `d_mask_i=3'b000`, address 0x3, data 0xAB.
  - `mem_we_o=1`, `mem_mask_o=3'b000`, `mem_wdata_o=0xAB`.
  - `d_rvalid_o` pulses MEM_LAT cycles later.
- Back-to-back: MEM_LAT=3, continuous data requests.
  - Grants occur every 3 cycles, exactly in each response cycle.
  - `busy_o` stays 1 throughout.
- Fairness, with `ARB_FAIRNESS_EN`, STARVE_MAX=4, MEM_LAT=1, both requesters continuous:
  - Four data grants, then one fetch grant, repeating.
  - Without the macro, the fetch grant never occurs.
- Reset mid-flight: MEM_LAT=4, `reset` driven low 2 cycles after a fetch grant.
  - No `if_rvalid_o` is emitted.
  - All outputs are 0 and `busy_o` is 0 on the next cycle.
